// File: rtl/multi_bus.sv
// Shared-bus crossbar: round-robin arbitration of PORTS sources onto one registered bus.
// Optional BUS_LOOPBACK_EN makes dst == own index a legal transfer.
module multi_bus #(
  parameter int WIDTH = 8,
  parameter int PORTS = 4,
  parameter int PIDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       req,
  input  logic [PORTS*PIDW-1:0]  dst,
  input  logic [PORTS*WIDTH-1:0] wdata,
  input  logic [PORTS-1:0]       dst_rdy,
  output logic [PORTS-1:0]       grant,
  output logic [PORTS-1:0]       out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [PIDW-1:0]        out_src,
  output logic                   err
);

  logic [PIDW-1:0]  rr;
  logic [PIDW-1:0]  rr_next;
  logic [PORTS-1:0] illegal;
  logic [PORTS-1:0] ready_at_dst;
  logic [PORTS-1:0] eligible;
  logic             found;
  logic [PIDW-1:0]  win;
  logic [PIDW-1:0]  win_dst;
  logic [WIDTH-1:0] win_data;
  logic             win_illegal;
  logic [PORTS-1:0] win_onehot;
  int               idx;

  // Illegal requests are always eligible so they drain even with no ready target.
  always_comb begin
    illegal      = '0;
    ready_at_dst = '0;
    eligible     = '0;
    for (int i = 0; i < PORTS; i++) begin
      illegal[i] = int'(dst[i*PIDW +: PIDW]) >= PORTS;
`ifndef BUS_LOOPBACK_EN
      if (int'(dst[i*PIDW +: PIDW]) == i) illegal[i] = 1'b1;
`endif
      for (int j = 0; j < PORTS; j++) begin
        if (int'(dst[i*PIDW +: PIDW]) == j) ready_at_dst[i] = dst_rdy[j];
      end
      eligible[i] = req[i] & (illegal[i] | ready_at_dst[i]);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(rr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PIDW'(idx);
      end
    end
  end

  always_comb begin
    win_dst     = dst[int'(win)*PIDW +: PIDW];
    win_data    = wdata[int'(win)*WIDTH +: WIDTH];
    win_illegal = 1'b0;
    grant       = '0;
    win_onehot  = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (int'(win) == j) begin
        win_illegal = illegal[j];
        grant[j]    = rst_n & found;
      end
      win_onehot[j] = (int'(win_dst) == j);
    end
    rr_next = (int'(win) == PORTS - 1) ? '0 : PIDW'(int'(win) + 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr        <= '0;
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= '0;
      err       <= 1'b0;
      if (found) begin
        rr <= rr_next;
        if (win_illegal) begin
          err <= 1'b1;
        end else begin
          out_valid <= win_onehot;
          out_data  <= win_data;
          out_src   <= win;
        end
      end
    end
  end

endmodule

// File: doc/multi_bus.md
MULTI_BUS -- requirements
Module: multi_bus

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits (1..32).
REQ-002 Parameter: PORTS, default 4, number of bus ports (2..8).
REQ-003 Parameter: PIDW, default 2, port-index width, SHALL equal ceil(log2(PORTS)).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: req  in  PORTS  per-source transfer request, held until granted.
REQ-007 Port: dst  in  PORTS*PIDW  per-source destination index; slice i = dst[i*PIDW +: PIDW].
REQ-008 Port: wdata  in  PORTS*WIDTH  per-source data; slice i = wdata[i*WIDTH +: WIDTH].
REQ-009 Port: dst_rdy  in  PORTS  per-destination ready to accept one word.
REQ-010 Port: grant  out  PORTS  combinational one-hot acceptance of source i this cycle.
REQ-011 Port: out_valid  out  PORTS  registered one-hot delivery strobe to destination.
REQ-012 Port: out_data  out  WIDTH  registered shared bus data, valid where out_valid is set.
REQ-013 Port: out_src  out  PIDW  registered source index of the delivered word.
REQ-014 Port: err  out  1  registered one-cycle pulse: illegal request consumed.

Function
REQ-015 Source i SHALL be eligible when req[i]=1 and either its destination is illegal, or dst_rdy[dst_i]=1.
REQ-016 Destination SHALL be illegal when dst_i >= PORTS, or dst_i == i with BUS_LOOPBACK_EN undefined.
REQ-017 At most one grant bit SHALL be set per cycle; a transfer is accepted on a rising edge where req[i] and grant[i] are both 1.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr and wraps modulo PORTS; the first eligible source wins.
REQ-019 After an accepted transfer from source i, rr SHALL become (i+1) mod PORTS; otherwise rr holds.
REQ-020 Legal accept at edge N: from edge N to edge N+1, out_valid SHALL be one-hot at dst_i, out_data=wdata_i, out_src=i (latency 1).
REQ-021 Illegal accept at edge N: from edge N to N+1, err=1 and out_valid=0; data is discarded; rr advances as in REQ-019.
REQ-022 If no transfer is accepted, out_valid and err SHALL be 0 on the next cycle; out_data and out_src SHALL hold their previous values.
REQ-023 Back-to-back transfers on consecutive cycles SHALL be supported, one per cycle.
REQ-024 A source whose destination is not ready SHALL be skipped without blocking other sources (no head-of-line blocking).
REQ-025 Once raised, req[i], dst_i and wdata_i SHALL be held stable by the source until grant[i]; the block SHALL not buffer more than one word.
REQ-026 grant SHALL be 0 whenever rst_n=0.

Reset
REQ-027 When rst_n=0 at a rising edge: rr=0, out_valid=0, out_data=0, out_src=0, err=0.
REQ-028 Reset mid-transfer SHALL drop the pending delivery; no out_valid pulse follows reset release.

Configuration
REQ-029 Macro BUS_LOOPBACK_EN defined: dst_i == i is legal and delivers to port i per REQ-020.
REQ-030 Macro BUS_LOOPBACK_EN undefined: dst_i == i is illegal, is consumed and pulses err per REQ-021.

Verification
REQ-031 PORTS=4, WIDTH=8: src1 req, dst=3, wdata=8'hA5, dst_rdy=4'hF -> grant=4'b0010 same cycle; next cycle out_valid=4'b1000, out_data=8'hA5, out_src=1.
REQ-032 req=4'b1111 held 4 cycles, all dst legal and ready, rr=0 -> grants 0,1,2,3 in order, one per cycle, with 4 consecutive deliveries.
REQ-033 src0 req dst=2 with dst_rdy[2]=0, src3 req dst=1 ready -> grant=4'b1000; src0 granted in the first cycle after dst_rdy[2] rises.
REQ-034 src2 req dst=2, wdata=8'h3C: with BUS_LOOPBACK_EN -> out_valid=4'b0100, out_data=8'h3C; without -> err=1 for one cycle, out_valid=0.
REQ-035 PORTS=3, src0 req dst=3 -> grant=3'b001, err=1 next cycle, no out_valid, rr=1.
REQ-036 rst_n=0 on the edge after an accept -> out_valid=0, out_data=0, rr=0; after release, req=4'b1010 -> first grant=4'b0010.
